emisor_instrucciones_tr: RTL and testbench
==========================================

Name: emisor_instrucciones_tr

Overview:
- Instruction issue unit: the producer end of the Instruccion_TR interface that DataPath_TipoR consumes.
- Holds a small loadable program memory of 32-bit R-type words.
- Steps a PC through it and presents one instruction at a time on Instruccion_TR with a valid/ready handshake.
- Stops on a halt sentinel word or at the end of memory; replaces hand-driven instruction stimulus.

Parameters:
- DEPTH, 32, number of program words.
- ADDR_W, 5, PC/address width; DEPTH = 2**ADDR_W.
- HALT_WORD, 32'hFFFF_FFFF, sentinel that ends the program (never issued).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  begin execution from address 0 (pulse).
- Carga_En  input  1  program-load write enable.
- Carga_Dir  input  ADDR_W  program-load address.
- Carga_Dato  input  32  program-load data word.
- Instruccion_TR  output  32  instruction presented to the datapath.
- Valido  output  1  Instruccion_TR holds a valid instruction.
- Listo  input  1  datapath accepts the instruction this cycle.
- PC  output  ADDR_W  address of the current or last fetched word.
- Ocupado  output  1  high in FETCH, CHECK and ISSUE.
- Fin  output  1  high in HALT.
- Emitidas  output  ADDR_W+1  count of accepted instructions since the last Start.

Behaviour:
- Reset (async, RST=1): state IDLE; Instruccion_TR=0, Valido=0, PC=0, Ocupado=0, Fin=0, Emitidas=0.
  - Takes effect immediately, including mid-handshake: Valido drops without waiting for a clock edge.
  - Program memory contents are not reset.
- Memory:
  - Synchronous write when Carga_En=1 and Ocupado=0.
  - Carga_En is ignored while Ocupado=1.
  - Read is registered, one cycle latency.
- States:
  - IDLE: Start=1 -> PC<=0, Emitidas<=0, go FETCH.
  - FETCH: issue read at PC -> CHECK.
  - CHECK:
    - read word == HALT_WORD -> HALT; Valido stays 0.
    - else Instruccion_TR<=word, Valido<=1 -> ISSUE.
  - ISSUE: hold Instruccion_TR and Valido=1 unchanged while Listo=0. On Listo=1 sampled:
    - Valido<=0 and Emitidas<=Emitidas+1.
    - if PC==DEPTH-1 -> HALT. No wrap; PC stays DEPTH-1.
    - else PC<=PC+1 -> FETCH.
  - HALT: Fin=1. Start=1 -> Fin<=0, PC<=0, Emitidas<=0 -> FETCH.
- Start is ignored in FETCH, CHECK and ISSUE.
- Listo is ignored whenever Valido=0.
- Instruccion_TR keeps its last issued value after the handshake; only Valido qualifies it.
- Latency:
  - Start sampled at edge N -> Valido=1 after edge N+2.
  - With Listo held high: one instruction per 3 cycles.
- Simultaneous events:
  - Start with Carga_En in IDLE or HALT: the write completes and the FSM leaves.
  - The write lands before the first fetch, so a write to address 0 is the word fetched.
- Emitidas saturates at DEPTH. It cannot exceed DEPTH by construction.

Test Plan:
- Load addr0=32'h0131_3820 (add r7,r9,r17), addr1=32'h0135_4820 (add r9,r9,r21), addr2=HALT_WORD; Start with Listo=1:
  - Instruccion_TR=32'h01313820 with Valido after edge N+2, then 32'h01354820 three cycles later.
  - Fin=1, Emitidas=2, PC=2.
- Backpressure: hold Listo=0 for 5 cycles during the first instruction -> Instruccion_TR=32'h01313820 and Valido=1 stable all 5 cycles; PC=0; Emitidas=0 until Listo rises.
- Fill all 32 words with 32'h0000_0020 (no HALT_WORD); run with Listo=1 -> 32 issues, Fin=1, PC=31, Emitidas=32, no wrap to 0.
- Assert RST while Valido=1 in ISSUE -> Valido, Ocupado and PC go 0 before the next CLK edge; a following Start replays from address 0 with the same words.
- Carga_En to addr1 with 32'h0000_0000 while Ocupado=1 -> ignored; addr1 still issues 32'h01354820.
- Start pulse during ISSUE -> ignored, no restart.
- Start in HALT -> Fin clears and the program reruns from address 0.

Source files
------------

// File: rtl/emisor_instrucciones_tr.sv
// Instruction issue unit: loadable program memory stepped by a PC, presenting one
// R-type word at a time on Instruccion_TR under a Valido/Listo handshake.
module emisor_instrucciones_tr #(
    parameter int          DEPTH     = 32,
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Carga_En,
    input  logic [ADDR_W-1:0] Carga_Dir,
    input  logic [31:0]       Carga_Dato,
    output logic [31:0]       Instruccion_TR,
    output logic              Valido,
    input  logic              Listo,
    output logic [ADDR_W-1:0] PC,
    output logic              Ocupado,
    output logic              Fin,
    output logic [ADDR_W:0]   Emitidas
);

    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   EMIT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic              valido_q, valido_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   emit_q, emit_d;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       rd_q;
    logic              wr_en;

    assign Ocupado = (state_q == S_FETCH) || (state_q == S_CHECK) || (state_q == S_ISSUE);
    assign Fin     = (state_q == S_HALT);
    assign wr_en   = Carga_En && !Ocupado;

    // Program memory is never reset; the read port samples continuously and is
    // consumed in CHECK, one cycle after FETCH has settled the PC.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[Carga_Dir] <= Carga_Dato;
        end
        rd_q <= mem_q[pc_q];
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        valido_d = valido_q;
        pc_d     = pc_q;
        emit_d   = emit_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    pc_d    = '0;
                    emit_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rd_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else begin
                    instr_d  = rd_q;
                    valido_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Listo) begin
                    valido_d = 1'b0;
                    if (emit_q != EMIT_MAX) begin
                        emit_d = emit_q + 1'b1;
                    end
                    // Last address ends the program rather than wrapping to 0.
                    if (pc_q == PC_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            valido_q <= 1'b0;
            pc_q     <= '0;
            emit_q   <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            valido_q <= valido_d;
            pc_q     <= pc_d;
            emit_q   <= emit_d;
        end
    end

    assign Instruccion_TR = instr_q;
    assign Valido         = valido_q;
    assign PC             = pc_q;
    assign Emitidas       = emit_q;

endmodule

// File: tb/tb_emisor_instrucciones_tr.sv
// Scoreboard bench for emisor_instrucciones_tr: expected issues are queued by the
// stimulus and popped by a monitor on every accepted handshake.
module tb_emisor_instrucciones_tr;

    localparam int          ADDR_W = 5;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
    localparam logic [31:0] W0     = 32'h0131_3820;
    localparam logic [31:0] W1     = 32'h0135_4820;
    localparam logic [31:0] WNOP   = 32'h0000_0020;

    logic              CLK;
    logic              RST;
    logic              Start;
    logic              Carga_En;
    logic [ADDR_W-1:0] Carga_Dir;
    logic [31:0]       Carga_Dato;
    logic [31:0]       Instruccion_TR;
    logic              Valido;
    logic              Listo;
    logic [ADDR_W-1:0] PC;
    logic              Ocupado;
    logic              Fin;
    logic [ADDR_W:0]   Emitidas;

    typedef struct packed {
        logic [31:0]       ins;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    emisor_instrucciones_tr dut (
        .CLK            (CLK),
        .RST            (RST),
        .Start          (Start),
        .Carga_En       (Carga_En),
        .Carga_Dir      (Carga_Dir),
        .Carga_Dato     (Carga_Dato),
        .Instruccion_TR (Instruccion_TR),
        .Valido         (Valido),
        .Listo          (Listo),
        .PC             (PC),
        .Ocupado        (Ocupado),
        .Fin            (Fin),
        .Emitidas       (Emitidas)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        Carga_En   = 1'b1;
        Carga_Dir  = a;
        Carga_Dato = d;
        tick();
        Carga_En   = 1'b0;
    endtask

    task automatic push(input logic [31:0] ins, input logic [ADDR_W-1:0] pc);
        exp_t e;
        e.ins = ins;
        e.pc  = pc;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_fin(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (Fin) break;
            tick();
        end
        chk("fin_reached", {31'd0, Fin}, 32'd1);
    endtask

    // Monitor: a handshake completes at the next rising edge whenever both are high.
    always @(negedge CLK) begin
        if (!RST && Valido && Listo) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got %h at pc %0d, expected no issue", Instruccion_TR, PC);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_word", Instruccion_TR, mon_e.ins);
                chk("issue_pc", {27'd0, PC}, {27'd0, mon_e.pc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        Start      = 1'b0;
        Carga_En   = 1'b0;
        Carga_Dir  = '0;
        Carga_Dato = '0;
        Listo      = 1'b0;
        #12;
        chk("rst_instr", Instruccion_TR, 32'd0);
        chk("rst_valido", {31'd0, Valido}, 32'd0);
        chk("rst_pc", {27'd0, PC}, 32'd0);
        chk("rst_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("rst_fin", {31'd0, Fin}, 32'd0);
        chk("rst_emitidas", {26'd0, Emitidas}, 32'd0);
        RST = 1'b0;
        tick();

        // Basic program with Listo held high: latency and 3-cycle cadence.
        load(5'd0, W0);
        load(5'd1, W1);
        load(5'd2, HALT);
        Listo = 1'b1;
        push(W0, 5'd0);
        push(W1, 5'd1);
        pulse_start();                                   // edge N
        chk("lat_n_valido", {31'd0, Valido}, 32'd0);
        chk("lat_n_ocupado", {31'd0, Ocupado}, 32'd1);
        tick();                                          // N+1
        chk("lat_n1_valido", {31'd0, Valido}, 32'd0);
        tick();                                          // N+2
        chk("lat_n2_valido", {31'd0, Valido}, 32'd1);
        chk("lat_n2_instr", Instruccion_TR, W0);
        tick();                                          // N+3: accepted
        chk("lat_n3_valido", {31'd0, Valido}, 32'd0);
        tick();
        tick();                                          // N+5
        chk("lat_n5_valido", {31'd0, Valido}, 32'd1);
        chk("lat_n5_instr", Instruccion_TR, W1);
        wait_fin(20);
        chk("t1_emitidas", {26'd0, Emitidas}, 32'd2);
        chk("t1_pc", {27'd0, PC}, 32'd2);
        chk("t1_valido", {31'd0, Valido}, 32'd0);
        chk("t1_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("t1_instr_held", Instruccion_TR, W1);

        // Restart from HALT with backpressure; Start and Carga_En during ISSUE ignored.
        Listo = 1'b0;
        push(W0, 5'd0);
        push(W1, 5'd1);
        pulse_start();
        chk("t2_fin_clear", {31'd0, Fin}, 32'd0);
        chk("t2_pc_zero", {27'd0, PC}, 32'd0);
        chk("t2_emit_zero", {26'd0, Emitidas}, 32'd0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valido", {31'd0, Valido}, 32'd1);
            chk("bp_instr", Instruccion_TR, W0);
            chk("bp_pc", {27'd0, PC}, 32'd0);
            chk("bp_emitidas", {26'd0, Emitidas}, 32'd0);
            if (k == 1) Start = 1'b1;
            if (k == 2) begin
                Start      = 1'b0;
                Carga_En   = 1'b1;
                Carga_Dir  = 5'd1;
                Carga_Dato = 32'd0;
            end
            if (k == 3) Carga_En = 1'b0;
            tick();
        end
        Listo = 1'b1;
        wait_fin(20);
        chk("t2_emitidas", {26'd0, Emitidas}, 32'd2);
        chk("t2_pc", {27'd0, PC}, 32'd2);

        // Asynchronous reset while the second instruction is being offered.
        Listo = 1'b0;
        pulse_start();
        tick();
        tick();
        chk("t3_first_valid", {31'd0, Valido}, 32'd1);
        Listo = 1'b1;
        push(W0, 5'd0);
        tick();
        Listo = 1'b0;
        tick();
        tick();
        chk("t3_second_valid", {31'd0, Valido}, 32'd1);
        chk("t3_second_pc", {27'd0, PC}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valido", {31'd0, Valido}, 32'd0);
        chk("arst_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("arst_pc", {27'd0, PC}, 32'd0);
        chk("arst_emitidas", {26'd0, Emitidas}, 32'd0);
        chk("arst_instr", Instruccion_TR, 32'd0);
        #3;
        RST = 1'b0;
        tick();
        Listo = 1'b1;
        push(W0, 5'd0);
        push(W1, 5'd1);
        pulse_start();
        wait_fin(20);
        chk("t3_emitidas", {26'd0, Emitidas}, 32'd2);

        // Full memory without a sentinel; the last write coincides with Start.
        for (int a = 1; a < 32; a++) load(ADDR_W'(a), WNOP);
        for (int a = 0; a < 32; a++) push(WNOP, ADDR_W'(a));
        Carga_En   = 1'b1;
        Carga_Dir  = 5'd0;
        Carga_Dato = WNOP;
        Start      = 1'b1;
        tick();
        Carga_En   = 1'b0;
        Start      = 1'b0;
        wait_fin(200);
        chk("t4_pc", {27'd0, PC}, 32'd31);
        chk("t4_emitidas", {26'd0, Emitidas}, 32'd32);
        chk("t4_valido", {31'd0, Valido}, 32'd0);
        chk("t4_instr_held", Instruccion_TR, WNOP);
        tick();
        tick();
        chk("t4_no_wrap_pc", {27'd0, PC}, 32'd31);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
